fetch_queue: RTL
================

# fetch_queue

Instruction fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the program counter, issues word-addressed requests to instruction memory over a valid/ready handshake, and collects in-order responses into a DEPTH-entry FIFO of {pc, instr} pairs. Decode drains the FIFO under backpressure. A taken-branch redirect flushes the queue and discards stale in-flight responses.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- RESET_PC, 32'd0: first fetch address after reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- redirect_valid  input  1  branch taken in MEM; flush and restart at redirect_pc
- redirect_pc  input  32  new fetch address
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  word address of request
- imem_req_ready  input  1  memory accepts request this cycle
- imem_rsp_valid  input  1  response valid; responses are in request order, ≥1 cycle after acceptance
- imem_rsp_data  input  32  instruction word
- out_valid  output  1  FIFO head valid toward IF/ID
- out_pc  output  32  PC of head instruction
- out_instr  output  32  head instruction
- out_ready  input  1  decode consumes head (low = stall)
- inflight  output  clog2(DEPTH)+1  outstanding accepted requests, including ones to be dropped

## Operation
- Registers: fetch_pc (next request address), rsp_pc (PC tagged on next kept response), FIFO with count, inflight counter, drop counter.
- Word addressing: the PC advances by 1 per instruction, not by 4. All PC arithmetic is modulo 2^32. 0xFFFFFFFF + 1 wraps to 0.
- Issue rule: imem_req_valid = (count + inflight < DEPTH) && !redirect_valid. imem_req_addr = fetch_pc.
- Accept (req_valid && req_ready): fetch_pc += 1 and inflight += 1.
- Response with drop = 0: push {rsp_pc, rsp_data} into the FIFO and increment rsp_pc. The credit rule guarantees space. A push into a full FIFO is a design error and is flagged by an assertion.
- Response with drop > 0: discard the data and decrement drop. rsp_pc is unchanged.
- Any response decrements inflight.
- Pop (out_valid && out_ready): advance the head and decrement count.
- Push and pop in the same cycle leave count unchanged, including when the FIFO is full.
- Redirect (redirect_valid = 1):
  - FIFO cleared (count = 0).
  - fetch_pc and rsp_pc set to redirect_pc.
  - drop = inflight + accept_this_cycle − rsp_this_cycle, i.e. every request still outstanding after this edge.
  - Any pop in the same cycle is ignored.
  - A response arriving in the same cycle is discarded and still decrements inflight.
  - No new request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins, and drop is recomputed each time.
- Behaviour state is given by drop: RUN when drop = 0, FLUSH when drop > 0. Requests to the new PC may issue during FLUSH. Their responses follow the dropped ones in order.

## Timing
- Reset values (asynchronous on rst = 0):
  - fetch_pc = rsp_pc = RESET_PC
  - count = inflight = drop = 0
  - imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0
- First request: imem_req_valid rises in the first cycle after rst deasserts.
- FIFO outputs are registered. A response pushed in cycle N is visible on out_* in cycle N+1.
- Minimum redirect-to-new-instruction latency, with 1-cycle memory and no stale requests:
  - redirect in cycle R
  - request in R+1
  - response in R+2
  - out_valid in R+3
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests must not be delivered by memory; this is a system requirement.
- Steady state with a 1-cycle memory and out_ready = 1 sustains one instruction per cycle.

## Test plan
- Reset then free run, 1-cycle memory, out_ready = 1 → out_pc = 0,1,2,3,…; first out_valid 3 cycles after rst rises; one instruction per cycle thereafter.
- Hold out_ready = 0 → count reaches 4 with inflight = 0, imem_req_valid = 0; release → out_pc continues gaplessly 0..7.
- 3-cycle memory latency, redirect to 0x40 while inflight = 3 → 3 responses discarded; next out_pc = 0x40 with the instruction at 0x40.
- Redirect in the same cycle as a response and a pop with count = 2 → count = 0, that response dropped, drop = inflight − 1, next out_pc = redirect_pc.
- Redirect to 0xFFFFFFFE → out_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- imem_req_ready held low for 5 cycles → imem_req_valid and imem_req_addr stay stable; no PC skip; sequence resumes correctly.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, instruction-memory and decode-side signals of the fetch front end.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     imem_req_valid;
  logic [31:0]              imem_req_addr;
  logic                     imem_req_ready;
  logic                     imem_rsp_valid;
  logic [31:0]              imem_rsp_data;
  logic                     out_valid;
  logic [31:0]              out_pc;
  logic [31:0]              out_instr;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   inflight;

  // Fetch unit side.
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_valid, out_pc, out_instr,
    input  out_ready,
    output inflight
  );

  // Environment side: branch unit, instruction memory, decode.
  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_pc, out_instr,
    output out_ready,
    input  inflight
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the word-addressed PC, issues credit-limited imem requests,
// queues in-order responses as {pc, instr} and flushes on a taken-branch redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {S_RUN, S_FLUSH} mode_e;

  logic          r_live;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic          w_redirect;
  logic          w_rsp;
  logic          w_accept;
  logic          w_credit;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occupancy;
  logic [CW-1:0] w_inflight_nxt;
  mode_e         w_mode;

  assign w_redirect  = bus.redirect_valid;
  assign w_rsp       = bus.imem_rsp_valid;
  // Queued plus outstanding entries bound issue, so every kept response has a slot.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit    = (w_occupancy < (CW+1)'(DEPTH));

  assign bus.imem_req_valid = r_live && w_credit && !w_redirect;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign w_accept           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.out_valid = (r_count != '0);
  assign bus.out_pc    = r_mem_pc[r_rd_ptr];
  assign bus.out_instr = r_mem_instr[r_rd_ptr];
  assign bus.inflight  = r_inflight;

  // Decode flush mode from the drop counter and classify this cycle's queue traffic.
  always_comb begin
    w_mode         = S_RUN;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_inflight_nxt = r_inflight;
    if (r_drop != '0) w_mode = S_FLUSH;
    w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(w_rsp);
    w_push         = w_rsp && (w_mode == S_RUN) && !w_redirect;
    w_pop          = bus.out_valid && bus.out_ready && !w_redirect;
  end

  // Fetch and response-tag PCs; r_live holds off the first request until one cycle after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live     <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
    end else begin
      r_live <= 1'b1;
      if (w_redirect) begin
        r_fetch_pc <= bus.redirect_pc;
        r_rsp_pc   <= bus.redirect_pc;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd1;
        if (w_push)   r_rsp_pc   <= r_rsp_pc + 32'd1;
      end
    end
  end

  // Outstanding-request, drop and occupancy counters plus queue pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_redirect) begin
        // Everything still outstanding after this edge belongs to the old path.
        r_drop   <= w_inflight_nxt;
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_rsp && (w_mode == S_FLUSH)) r_drop <= r_drop - CW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage, cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
      r_mem_instr[r_wr_ptr] <= bus.imem_rsp_data;
    end
  end

  // Credit accounting must never let a response land in a full queue.
  always_ff @(posedge clk) begin
    if (rst) assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
  end
endmodule
